// File: rtl/intra_pkg.sv
// Shared types and helpers for the intra prediction path.
// Sample extraction and the signed working width for Paeth distances.
package intra_pkg;

    localparam int WORK_EXTRA = 2;
    localparam int MAX_BD     = 16;
    localparam int MAX_PIX    = 512;

    // Default-build pixel layout: channel c in bits [c*PIX_BD +: PIX_BD]
    localparam int PIX_BD = 10;
    localparam int PIX_CH = 3;
    typedef logic [PIX_CH-1:0][PIX_BD-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } paeth_state_e;

    function automatic int work_w(input int bd);
        return bd + WORK_EXTRA;
    endfunction

    function automatic logic [MAX_BD-1:0] ch_sample(
        input logic [MAX_PIX-1:0] pix,
        input int                 c,
        input int                 bd
    );
        logic [MAX_PIX-1:0] sh;
        sh = pix >> (c * bd);
        return sh[MAX_BD-1:0] & ((MAX_BD'(1) << bd) - MAX_BD'(1));
    endfunction

endpackage

// File: rtl/paeth_core.sv
// Single-channel Paeth datapath: distance half (S1) and select half (S2).
// Both halves are combinational; the pipeline register sits in the top level.
module paeth_core
    import intra_pkg::*;
#(
    parameter  int BITDEPTH = 10,
    localparam int WW       = work_w(BITDEPTH)
) (
    input  logic [BITDEPTH-1:0] t,
    input  logic [BITDEPTH-1:0] l,
    input  logic [BITDEPTH-1:0] tl,
    output logic [WW-1:0]       p_l,
    output logic [WW-1:0]       p_t,
    output logic [WW-1:0]       p_tl,
    input  logic [BITDEPTH-1:0] s_t,
    input  logic [BITDEPTH-1:0] s_l,
    input  logic [BITDEPTH-1:0] s_tl,
    input  logic [WW-1:0]       s_pl,
    input  logic [WW-1:0]       s_pt,
    input  logic [WW-1:0]       s_ptl,
    output logic [BITDEPTH-1:0] pred
);
    logic signed [WW-1:0] ts, ls, tls;
    logic signed [WW-1:0] d_t, d_l, d_tl;

    assign ts  = $signed({2'b00, t});
    assign ls  = $signed({2'b00, l});
    assign tls = $signed({2'b00, tl});

    // Two guard bits keep T+L-2*TL inside the signed range
    assign d_t  = ts - tls;
    assign d_l  = ls - tls;
    assign d_tl = ts + ls - (tls <<< 1);

    assign p_l  = d_t[WW-1]  ? -d_t  : d_t;
    assign p_t  = d_l[WW-1]  ? -d_l  : d_l;
    assign p_tl = d_tl[WW-1] ? -d_tl : d_tl;

    always_comb begin
        pred = s_tl;
        if (s_pl <= s_pt && s_pl <= s_ptl)
            pred = s_l;
        else if (s_pt <= s_ptl)
            pred = s_t;
    end

endmodule

// File: rtl/paeth_pred_stream.sv
// Streaming Paeth intra predictor: edge set in, BWxBH block out in raster order.
// Define PAETH_OUT_REG_EN to add a 2-entry output skid buffer (+1 cycle latency).
module paeth_pred_stream
    import intra_pkg::*;
#(
    parameter int BITDEPTH = 10,
    parameter int CHANNELS = 3,
    parameter int BW       = 8,
    parameter int BH       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*BITDEPTH-1:0] in_topleft,
    input  logic [CHANNELS*BITDEPTH-1:0] in_above [0:BW-1],
    input  logic [CHANNELS*BITDEPTH-1:0] in_left  [0:BH-1],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*BITDEPTH-1:0] out_pix,
    output logic [$clog2(BW)-1:0]        out_x,
    output logic [$clog2(BH)-1:0]        out_y,
    output logic                         out_last
);
    localparam int PW = CHANNELS * BITDEPTH;
    localparam int XW = $clog2(BW);
    localparam int YW = $clog2(BH);
    localparam int WW = work_w(BITDEPTH);

    paeth_state_e state, state_n;

    logic [PW-1:0] tl_q;
    logic [PW-1:0] above_q [0:BW-1];
    logic [PW-1:0] left_q  [0:BH-1];
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    logic          accept, stall, issue_last;
    logic [PW-1:0] cur_t, cur_l, sel_pix;
    logic [CHANNELS-1:0][WW-1:0] p_l, p_t, p_tl;

    logic          s1_valid, s1_last;
    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;
    logic [PW-1:0] s1_t, s1_l, s1_tl;
    logic [CHANNELS-1:0][WW-1:0] s1_pl, s1_pt, s1_ptl;

    logic          s2_valid, s2_last;
    logic [XW-1:0] s2_x;
    logic [YW-1:0] s2_y;
    logic [PW-1:0] s2_pix;

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && in_ready;
    assign issue_last = (x_q == XW'(BW - 1)) && (y_q == YW'(BH - 1));
    assign cur_t      = above_q[x_q];
    assign cur_l      = left_q[y_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = RUN;
            RUN:     if (!stall && issue_last) state_n = DRAIN;
            DRAIN:   if (out_valid && out_ready && out_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tl_q <= '0;
            for (int i = 0; i < BW; i++) above_q[i] <= '0;
            for (int i = 0; i < BH; i++) left_q[i] <= '0;
            x_q <= '0;
            y_q <= '0;
        end else if (accept) begin
            tl_q <= in_topleft;
            for (int i = 0; i < BW; i++) above_q[i] <= in_above[i];
            for (int i = 0; i < BH; i++) left_q[i] <= in_left[i];
            x_q <= '0;
            y_q <= '0;
        end else if (state == RUN && !stall) begin
            // Power-of-two dimensions let both counters wrap naturally
            x_q <= x_q + XW'(1);
            if (x_q == XW'(BW - 1)) y_q <= y_q + YW'(1);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        paeth_core #(.BITDEPTH(BITDEPTH)) u_core (
            .t     (BITDEPTH'(ch_sample(MAX_PIX'(cur_t), c, BITDEPTH))),
            .l     (BITDEPTH'(ch_sample(MAX_PIX'(cur_l), c, BITDEPTH))),
            .tl    (BITDEPTH'(ch_sample(MAX_PIX'(tl_q), c, BITDEPTH))),
            .p_l   (p_l[c]),
            .p_t   (p_t[c]),
            .p_tl  (p_tl[c]),
            .s_t   (s1_t[c*BITDEPTH +: BITDEPTH]),
            .s_l   (s1_l[c*BITDEPTH +: BITDEPTH]),
            .s_tl  (s1_tl[c*BITDEPTH +: BITDEPTH]),
            .s_pl  (s1_pl[c]),
            .s_pt  (s1_pt[c]),
            .s_ptl (s1_ptl[c]),
            .pred  (sel_pix[c*BITDEPTH +: BITDEPTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_t     <= '0;
            s1_l     <= '0;
            s1_tl    <= '0;
            s1_pl    <= '0;
            s1_pt    <= '0;
            s1_ptl   <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_pix   <= '0;
        end else if (!stall) begin
            s1_valid <= (state == RUN);
            s1_last  <= (state == RUN) && issue_last;
            s1_x     <= x_q;
            s1_y     <= y_q;
            s1_t     <= cur_t;
            s1_l     <= cur_l;
            s1_tl    <= tl_q;
            s1_pl    <= p_l;
            s1_pt    <= p_t;
            s1_ptl   <= p_tl;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_x     <= s1_x;
            s2_y     <= s1_y;
            s2_pix   <= sel_pix;
        end
    end

`ifdef PAETH_OUT_REG_EN
    typedef struct packed {
        logic [PW-1:0] pix;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          last;
    } out_ent_t;

    out_ent_t   sk_mem [0:1];
    logic [1:0] sk_cnt;
    logic       sk_wr, sk_rd, sk_push, sk_pop;

    // Stall comes only from the registered fill level, never from out_ready
    assign stall   = (sk_cnt == 2'd2);
    assign sk_push = s2_valid && !stall;
    assign sk_pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sk_mem[0] <= '0;
            sk_mem[1] <= '0;
            sk_cnt    <= '0;
            sk_wr     <= 1'b0;
            sk_rd     <= 1'b0;
        end else begin
            if (sk_push) begin
                sk_mem[sk_wr] <= '{s2_pix, s2_x, s2_y, s2_last};
                sk_wr         <= ~sk_wr;
            end
            if (sk_pop) sk_rd <= ~sk_rd;
            sk_cnt <= sk_cnt + {1'b0, sk_push} - {1'b0, sk_pop};
        end
    end

    assign out_valid = (sk_cnt != 2'd0);
    assign out_pix   = sk_mem[sk_rd].pix;
    assign out_x     = sk_mem[sk_rd].x;
    assign out_y     = sk_mem[sk_rd].y;
    assign out_last  = sk_mem[sk_rd].last;
`else
    assign stall     = s2_valid && !out_ready;
    assign out_valid = s2_valid;
    assign out_pix   = s2_pix;
    assign out_x     = s2_x;
    assign out_y     = s2_y;
    assign out_last  = s2_last;
`endif

endmodule

// File: tb/tb_paeth_pred_stream.sv
// Bench for paeth_pred_stream (BITDEPTH=10, CHANNELS=3, BW=BH=4).
// Directed and random blocks compared against a base-distance Paeth model.
module tb_paeth_pred_stream;
    localparam int BD   = 10;
    localparam int CH   = 3;
    localparam int BW   = 4;
    localparam int BH   = 4;
    localparam int PW   = BD * CH;
    localparam int NPIX = BW * BH;
`ifdef PAETH_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready;
    logic          out_valid, out_ready, out_last;
    logic [PW-1:0] in_topleft, out_pix;
    logic [PW-1:0] in_above [0:BW-1];
    logic [PW-1:0] in_left  [0:BH-1];
    logic [1:0]    out_x, out_y;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] m_tl;
    logic [PW-1:0] m_above [0:BW-1];
    logic [PW-1:0] m_left  [0:BH-1];
    logic [PW-1:0] exp_q [$];
    int            lat, idle_at;
    bit            aborted;

    always #5 clk = ~clk;

    paeth_pred_stream #(
        .BITDEPTH(BD), .CHANNELS(CH), .BW(BW), .BH(BH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_topleft(in_topleft), .in_above(in_above), .in_left(in_left),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pix(out_pix), .out_x(out_x), .out_y(out_y),
        .out_last(out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Classic Paeth: distances of each neighbour to base = T + L - TL
    function automatic logic [PW-1:0] paeth_ref(input logic [PW-1:0] t,
            input logic [PW-1:0] l, input logic [PW-1:0] tl);
        logic [PW-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            int a, b, d, base, pl, pt, ptl, s;
            a = int'(t[c*BD +: BD]);
            b = int'(l[c*BD +: BD]);
            d = int'(tl[c*BD +: BD]);
            base = a + b - d;
            pl  = iabs(base - b);
            pt  = iabs(base - a);
            ptl = iabs(base - d);
            if (pl <= pt && pl <= ptl) s = b;
            else if (pt <= ptl)        s = a;
            else                       s = d;
            r[c*BD +: BD] = BD'(s);
        end
        return r;
    endfunction

    task automatic set_uniform(input logic [PW-1:0] tlv,
            input logic [PW-1:0] av, input logic [PW-1:0] lv);
        m_tl = tlv;
        for (int i = 0; i < BW; i++) m_above[i] = av;
        for (int i = 0; i < BH; i++) m_left[i] = lv;
    endtask

    task automatic set_random(input int maxv);
        for (int c = 0; c < CH; c++) begin
            m_tl[c*BD +: BD] = BD'($urandom_range(0, maxv));
            for (int i = 0; i < BW; i++)
                m_above[i][c*BD +: BD] = BD'($urandom_range(0, maxv));
            for (int i = 0; i < BH; i++)
                m_left[i][c*BD +: BD] = BD'($urandom_range(0, maxv));
        end
    endtask

    task automatic do_abort();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_pix", 32'(out_pix), 0);
        check("rst_out_x", 32'(out_x), 0);
        check("rst_out_y", 32'(out_y), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 1);
        check("post_rst_valid", 32'(out_valid), 0);
    endtask

    task automatic run_block(input bit rnd, input int abort_at);
        int got, cyc;
        got = 0;
        lat = -1;
        idle_at = -1;
        aborted = 1'b0;
        exp_q.delete();
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                exp_q.push_back(paeth_ref(m_above[x], m_left[y], m_tl));
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_topleft = m_tl;
        for (int i = 0; i < BW; i++) in_above[i] = m_above[i];
        for (int i = 0; i < BH; i++) in_left[i] = m_left[i];
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble the edge inputs: the block must use the captured set
        in_topleft = PW'($urandom);
        for (int i = 0; i < BW; i++) in_above[i] = PW'($urandom);
        for (int i = 0; i < BH; i++) in_left[i] = PW'($urandom);
        check("ready_low_after_accept", 32'(in_ready), 0);
        cyc = 1;
        while (cyc < 400) begin
            if (out_valid && lat < 0) lat = cyc - 1;
            if (in_ready) begin
                idle_at = cyc - 1;
                break;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (got < NPIX) begin
                    check("pix", 32'(out_pix), 32'(exp_q[got]));
                    check("x", 32'(out_x), got % BW);
                    check("y", 32'(out_y), got / BW);
                    check("last", 32'(out_last), 32'(got == NPIX - 1));
                end
                got++;
                if (got == abort_at) begin
                    aborted = 1'b1;
                    do_abort();
                    return;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("pixel_count", got, NPIX);
        check("first_valid_latency", lat, LAT);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_topleft = '0;
        for (int i = 0; i < BW; i++) in_above[i] = '0;
        for (int i = 0; i < BH; i++) in_left[i] = '0;
        #12;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_pix", 32'(out_pix), 0);
        check("reset_out_x", 32'(out_x), 0);
        check("reset_out_y", 32'(out_y), 0);
        check("reset_out_last", 32'(out_last), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Flat edges: Paeth picks top-left on every channel
        set_uniform({3{10'd100}}, {3{10'd120}}, {3{10'd80}});
        run_block(1'b0, -1);
        check("block_cycles", idle_at, NPIX + LAT);

        // Max-valued edges, tie resolves to left
        set_uniform({3{10'd0}}, {3{10'd1023}}, {3{10'd1023}});
        run_block(1'b0, -1);
        check("hi_block_cycles", idle_at, NPIX + LAT);

        // Negative base handled as signed
        set_uniform({3{10'd1023}}, {3{10'd0}}, {3{10'd0}});
        run_block(1'b0, -1);

        // Channel 0 only: top wins there, zeros elsewhere
        set_uniform({20'd0, 10'd10}, {20'd0, 10'd50}, {20'd0, 10'd12});
        run_block(1'b0, -1);
        check("ch0_top_value", 32'(exp_q[0]), 32'd50);

        for (int b = 0; b < 4; b++) begin
            set_random(b == 3 ? 3 : 1023);
            run_block(1'b1, -1);
        end

        set_random(1023);
        run_block(1'b1, 7);
        check("abort_reached", 32'(aborted), 1);
        set_random(1023);
        run_block(1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
